rain_sequencer: RTL

- Frame/animation controller for the glyph-rain VGA datapath.
- Replaces the ad-hoc vsync-clocked frame counter with a single-clock-domain sequencer.
- Generates the animation frame number, the intro-drop enable and the palette select.
- Adds pause, single-step and speed control from the dedicated input pins.
- Sits between hvsync_generator (vsync) and the rain/glyph/palette datapath.

---
 rtl/rain_pkg.sv | 14 +
 rtl/rain_sequencer_btn_conditioner.sv | 69 ++++++
 rtl/rain_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rain_pkg.sv
// Shared types and constants for the glyph-rain frame sequencer.
package rain_pkg;

  localparam int FRAME_W_DEF   = 10;
  localparam int PAL_W_DEF     = 2;
  localparam int PAL_WRAP_BITS = 8;

  typedef enum logic [1:0] {
    INTRO  = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/rain_sequencer_btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, optional debouncer, registered rising-edge pulse.
// Optional debouncer enabled by defining RAIN_SEQ_DEBOUNCE_EN.
module btn_conditioner #(
  parameter int DEB_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

`ifdef RAIN_SEQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] deb_cnt;
  logic             deb_lvl;

  // Level flips only after the synchronized input differs for DEB_CYCLES straight cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b0;
    end else if (sync2 != deb_lvl) begin
      if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        deb_lvl <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign level = deb_lvl;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/rain_sequencer.sv
// Frame/animation sequencer: frame counter, intro-drop flag, palette id, pause/step/speed control.
// Optional button debouncing enabled by defining RAIN_SEQ_DEBOUNCE_EN.
import rain_pkg::*;

module rain_sequencer #(
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int PAL_W      = PAL_W_DEF,
  parameter int DEB_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               pause_btn,
  input  logic               step_btn,
  input  logic [1:0]         speed,
  input  logic               auto_pal,
  input  logic [PAL_W-1:0]   pal_sel,
  output logic [FRAME_W-1:0] frame,
  output logic               intro_done,
  output logic [PAL_W-1:0]   pid,
  output logic               frame_tick,
  output logic               paused
);

  if (FRAME_W < PAL_WRAP_BITS) begin : g_bad_frame_w
    $error("FRAME_W must be at least PAL_WRAP_BITS");
  end

  seq_state_t state;
  seq_state_t state_nxt;
  logic       step_pending;
  logic       step_nxt;
  logic       vsync_q;
  logic       vs_rise;
  logic [1:0] div_cnt;
  logic       adv_ok;
  logic       advance;
  logic       pause_ev;
  logic       step_ev;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_pause_cond (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (pause_btn),
    .pulse (pause_ev)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step_cond (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (step_btn),
    .pulse (step_ev)
  );

  assign vs_rise = vsync & ~vsync_q;
  // >= so that lowering speed mid-count releases the divider on the next vsync.
  assign adv_ok  = vs_rise && (div_cnt >= speed);
  assign paused  = (state == PAUSED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      div_cnt <= 2'd0;
    end else begin
      vsync_q <= vsync;
      if (vs_rise) begin
        if (adv_ok) div_cnt <= 2'd0;
        else        div_cnt <= div_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step_pending;
    advance   = 1'b0;
    case (state)
      INTRO: begin
        advance = adv_ok;
        if (adv_ok && (frame == '1)) state_nxt = RUN;
      end
      RUN: begin
        advance = adv_ok;
        if (pause_ev) state_nxt = PAUSED;
      end
      PAUSED: begin
        if (step_ev) step_nxt = 1'b1;
        if (adv_ok && (step_pending || step_ev)) begin
          advance  = 1'b1;
          step_nxt = 1'b0;
        end
        if (pause_ev) begin
          state_nxt = RUN;
          step_nxt  = 1'b0;
        end
      end
      default: state_nxt = INTRO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INTRO;
      step_pending <= 1'b0;
      frame        <= '0;
      frame_tick   <= 1'b0;
      intro_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      step_pending <= step_nxt;
      frame_tick   <= advance;
      if (advance) frame <= frame + 1'b1;
      if ((state == INTRO) && (state_nxt == RUN)) intro_done <= 1'b1;
    end
  end

  // Manual palette is latched on vsync so a pal_sel change never lands mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid <= '0;
    end else if (!auto_pal) begin
      if (vs_rise) pid <= pal_sel;
    end else if (advance && (frame[PAL_WRAP_BITS-1:0] == '1)) begin
      pid <= pid + 1'b1;
    end
  end

endmodule
